reg_file_rename: RTL and testbench
==================================

# reg_file_rename

Architectural register file with per-register rename tags; the commit-side counterpart of the reorder buffer. At issue it records which ROB entry will produce each destination register. At commit it takes the ROB's retired result and writes it into architectural state. Every cycle it returns, for the two source registers of the instruction being issued, either a committed value or the ROB tag the consumer must wait on.

## Interface
- REG_NUM, 32, number of architectural registers (x0 hardwired zero)
- REG_WIDTH, 5, register index width
- VAL_WIDTH, 32, data width
- ID_WIDTH, 4, ROB tag width
- clk  in  1  system clock, all state updates on rising edge
- rst_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global enable; when 0 all state holds
- flush_in  in  1  misprediction flush from ROB
- issue_en  in  1  an instruction with a destination is being issued this cycle
- issue_rd  in  REG_WIDTH  destination register of issuing instruction
- issue_tag  in  ID_WIDTH  ROB tag allocated to issuing instruction
- commit_en  in  1  ROB retires an instruction with a register result
- commit_rd  in  REG_WIDTH  destination of retiring instruction
- commit_res  in  VAL_WIDTH  result of retiring instruction
- commit_lab  in  ID_WIDTH  ROB tag of retiring instruction
- rs1_idx, rs2_idx  in  REG_WIDTH  source registers of issuing instruction
- rf_busy1, rf_busy2  out  1  source still awaits a ROB result
- rf_label1, rf_label2  out  ID_WIDTH  ROB tag to wait on (0 when not busy)
- rf_val1, rf_val2  out  VAL_WIDTH  committed value (0 when busy)

## Operation
- State: val[REG_NUM], busy[REG_NUM], tag[REG_NUM].
- Reset (rst_in=0, immediate, no clock needed): all val=0, busy=0, tag=0. All outputs read 0.
- rdy_in=0: no state change. Read outputs stay combinational on current state.
- Commit (commit_en=1, rdy_in=1, commit_rd!=0):
  - val[commit_rd] <= commit_res, unconditionally.
  - If busy[commit_rd] and tag[commit_rd]==commit_lab: busy <= 0, tag <= 0.
  - Otherwise a younger producer owns the register; busy/tag unchanged.
- Issue (issue_en=1, rdy_in=1, flush_in=0, issue_rd!=0): busy[issue_rd] <= 1, tag[issue_rd] <= issue_tag.
- Issue and commit to the same rd in one cycle: val takes commit_res; busy=1 and tag=issue_tag. Issue wins the rename fields.
- Flush (flush_in=1, rdy_in=1): all busy <= 0 and all tag <= 0; val is retained. A commit in the same cycle is still written to val. Issue in the same cycle is ignored.
- Writes to x0 (issue or commit) are ignored. Reads of x0 give busy=0, label=0, val=0.
- Read, per source port k, combinational:
  - If idx==0: not busy, value 0.
  - Else if commit_en and commit_rd==idx and busy[idx] and tag[idx]==commit_lab: bypass, busy=0, label=0, val=commit_res.
  - Else if busy[idx]: busy=1, label=tag[idx], val=0.
  - Else: busy=0, label=0, val=val[idx].
- The read does not see a same-cycle issue, because sources are read before the instruction's own destination is renamed. Example: rs1==issue_rd returns the previous producer.

## Timing
- Read path: zero latency, combinational from rs*_idx, state and commit inputs.
- Issue/commit/flush effects are visible on the read ports from the cycle after the edge.
- Commit→consumer latency: 0 cycles via bypass, otherwise 1 cycle.
- Asynchronous reset overrides everything, including mid-commit. The first state update after deassertion occurs at the next rising edge with rdy_in=1.

## Test plan
- Reset then read: drive rst_in=0 with x5 previously written. Required: rf_busy1=0 and rf_val1=0 immediately, with no clock edge.
- Issue/commit: issue rd=3, tag=2, then read rs1=3. Required: busy=1, label=2. Commit rd=3, lab=2, res=0xDEADBEEF. Required: same-cycle read gives busy=0, val=0xDEADBEEF, and the next cycle gives the same.
- Stale commit: issue rd=4 tag=1, then issue rd=4 tag=5, then commit rd=4 lab=1 res=7. Required: val[4]=7, and the read stays busy=1, label=5.
- Same-cycle issue+commit on rd=6 (issue tag=3, commit lab=1 matching, res=9). Required: next cycle busy=1, label=3; after commit lab=3 res=11, val=11.
- Flush: rename x1,x2 (tags 1,2), flush_in=1 with commit rd=7 res=0x55. Required: next cycle x1/x2 not busy and hold their old values; x7=0x55.
- x0 and rdy_in: issue/commit rd=0 leaves x0 reading 0 and not busy. With rdy_in=0, commit rd=8 res=1 has no effect.

Source files
------------

// File: rtl/reg_file_rename_if.sv
// Issue/commit/read bundle between the rename-side register file and its ROB/issue stage.
// The master drives control and indices; the slave (register file) returns the source operand reads.
interface reg_file_rename_if #(
    parameter int REG_WIDTH = 5,
    parameter int VAL_WIDTH = 32,
    parameter int ID_WIDTH  = 4
) ();
    logic                 rdy_in;
    logic                 flush_in;
    logic                 issue_en;
    logic [REG_WIDTH-1:0] issue_rd;
    logic [ID_WIDTH-1:0]  issue_tag;
    logic                 commit_en;
    logic [REG_WIDTH-1:0] commit_rd;
    logic [VAL_WIDTH-1:0] commit_res;
    logic [ID_WIDTH-1:0]  commit_lab;
    logic [REG_WIDTH-1:0] rs1_idx;
    logic [REG_WIDTH-1:0] rs2_idx;
    logic                 rf_busy1;
    logic                 rf_busy2;
    logic [ID_WIDTH-1:0]  rf_label1;
    logic [ID_WIDTH-1:0]  rf_label2;
    logic [VAL_WIDTH-1:0] rf_val1;
    logic [VAL_WIDTH-1:0] rf_val2;

    modport master (
        output rdy_in, flush_in, issue_en, issue_rd, issue_tag,
        output commit_en, commit_rd, commit_res, commit_lab, rs1_idx, rs2_idx,
        input  rf_busy1, rf_busy2, rf_label1, rf_label2, rf_val1, rf_val2
    );

    modport slave (
        input  rdy_in, flush_in, issue_en, issue_rd, issue_tag,
        input  commit_en, commit_rd, commit_res, commit_lab, rs1_idx, rs2_idx,
        output rf_busy1, rf_busy2, rf_label1, rf_label2, rf_val1, rf_val2
    );
endinterface

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register ROB rename tags.
// Issue renames a destination, commit retires a result, and two source ports read value-or-tag with commit bypass.
module reg_file_rename #(
    parameter int REG_NUM   = 32,
    parameter int REG_WIDTH = 5,
    parameter int VAL_WIDTH = 32,
    parameter int ID_WIDTH  = 4
) (
    input  logic               clk,
    input  logic               rst_in,
    reg_file_rename_if.slave   rf_bus
);

    logic [VAL_WIDTH-1:0] r_val [REG_NUM];
    logic [ID_WIDTH-1:0]  r_tag [REG_NUM];
    logic [REG_NUM-1:0]   r_busy;

    logic [REG_WIDTH-1:0] w_idx   [2];
    logic                 w_busy  [2];
    logic [ID_WIDTH-1:0]  w_label [2];
    logic [VAL_WIDTH-1:0] w_val   [2];

    logic w_commit_ok;
    logic w_commit_match;
    logic w_issue_ok;

    assign w_commit_ok    = rf_bus.commit_en && (rf_bus.commit_rd != '0);
    assign w_commit_match = r_busy[rf_bus.commit_rd] && (r_tag[rf_bus.commit_rd] == rf_bus.commit_lab);
    assign w_issue_ok     = rf_bus.issue_en && !rf_bus.flush_in && (rf_bus.issue_rd != '0);

    // Later assignments win: issue overrides the commit's busy clear on the same register.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            r_busy <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                r_val[i] <= '0;
                r_tag[i] <= '0;
            end
        end else if (rf_bus.rdy_in) begin
            if (w_commit_ok) begin
                r_val[rf_bus.commit_rd] <= rf_bus.commit_res;
                if (w_commit_match) begin
                    r_busy[rf_bus.commit_rd] <= 1'b0;
                    r_tag[rf_bus.commit_rd]  <= '0;
                end
            end
            if (rf_bus.flush_in) begin
                r_busy <= '0;
                for (int i = 0; i < REG_NUM; i++) begin
                    r_tag[i] <= '0;
                end
            end else if (w_issue_ok) begin
                r_busy[rf_bus.issue_rd] <= 1'b1;
                r_tag[rf_bus.issue_rd]  <= rf_bus.issue_tag;
            end
        end
    end

    assign w_idx[0] = rf_bus.rs1_idx;
    assign w_idx[1] = rf_bus.rs2_idx;

    // Reads see state before this cycle's issue; a matching commit is forwarded directly.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_busy[k]  = 1'b0;
            w_label[k] = '0;
            w_val[k]   = '0;
            if (w_idx[k] != '0) begin
                if (rf_bus.commit_en && (rf_bus.commit_rd == w_idx[k]) &&
                    r_busy[w_idx[k]] && (r_tag[w_idx[k]] == rf_bus.commit_lab)) begin
                    w_val[k] = rf_bus.commit_res;
                end else if (r_busy[w_idx[k]]) begin
                    w_busy[k]  = 1'b1;
                    w_label[k] = r_tag[w_idx[k]];
                end else begin
                    w_val[k] = r_val[w_idx[k]];
                end
            end
        end
    end

    assign rf_bus.rf_busy1  = w_busy[0];
    assign rf_bus.rf_label1 = w_label[0];
    assign rf_bus.rf_val1   = w_val[0];
    assign rf_bus.rf_busy2  = w_busy[1];
    assign rf_bus.rf_label2 = w_label[1];
    assign rf_bus.rf_val2   = w_val[1];

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed vector bench for reg_file_rename: per-cycle stimulus with hand-computed pre-edge reads,
// followed by hand-written reset sequences.
module tb_reg_file_rename;

    logic clk;
    logic rst_in;
    int   total;
    int   bad;

    reg_file_rename_if #(.REG_WIDTH(5), .VAL_WIDTH(32), .ID_WIDTH(4)) bus ();

    reg_file_rename #(.REG_NUM(32), .REG_WIDTH(5), .VAL_WIDTH(32), .ID_WIDTH(4)) dut (
        .clk    (clk),
        .rst_in (rst_in),
        .rf_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        flush;
        logic        ien;
        logic [4:0]  ird;
        logic [3:0]  itag;
        logic        cen;
        logic [4:0]  crd;
        logic [3:0]  clab;
        logic [31:0] cres;
        logic [4:0]  rs1;
        logic        b1;
        logic [3:0]  l1;
        logic [31:0] v1;
        logic [4:0]  rs2;
        logic        b2;
        logic [3:0]  l2;
        logic [31:0] v2;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic rdy, input logic flush,
                                input logic ien, input logic [4:0] ird, input logic [3:0] itag,
                                input logic cen, input logic [4:0] crd, input logic [3:0] clab,
                                input logic [31:0] cres,
                                input logic [4:0] rs1, input logic b1, input logic [3:0] l1,
                                input logic [31:0] v1,
                                input logic [4:0] rs2, input logic b2, input logic [3:0] l2,
                                input logic [31:0] v2);
        vec_t v;
        v.rdy = rdy; v.flush = flush; v.ien = ien; v.ird = ird; v.itag = itag;
        v.cen = cen; v.crd = crd; v.clab = clab; v.cres = cres;
        v.rs1 = rs1; v.b1 = b1; v.l1 = l1; v.v1 = v1;
        v.rs2 = rs2; v.b2 = b2; v.l2 = l2; v.v2 = v2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.rdy_in     = v.rdy;
        bus.flush_in   = v.flush;
        bus.issue_en   = v.ien;
        bus.issue_rd   = v.ird;
        bus.issue_tag  = v.itag;
        bus.commit_en  = v.cen;
        bus.commit_rd  = v.crd;
        bus.commit_lab = v.clab;
        bus.commit_res = v.cres;
        bus.rs1_idx    = v.rs1;
        bus.rs2_idx    = v.rs2;
    endtask

    task automatic chk_ports(input string tag, input vec_t v);
        chk({tag, "_busy1"},  {31'd0, bus.rf_busy1}, {31'd0, v.b1});
        chk({tag, "_label1"}, {28'd0, bus.rf_label1}, {28'd0, v.l1});
        chk({tag, "_val1"},   bus.rf_val1, v.v1);
        chk({tag, "_busy2"},  {31'd0, bus.rf_busy2}, {31'd0, v.b2});
        chk({tag, "_label2"}, {28'd0, bus.rf_label2}, {28'd0, v.l2});
        chk({tag, "_val2"},   bus.rf_val2, v.v2);
    endtask

    initial begin
        vec_t idle;
        vec_t v;
        total = 0;
        bad   = 0;

        //      rdy fl ien ird itag cen crd clab cres           rs1 b1 l1 v1            rs2 b2 l2 v2
        vq.push_back(mk(1,0, 1, 3,2, 0, 0,0,32'h0,          3,0,0,32'h0,          0,0,0,32'h0));
        vq.push_back(mk(1,0, 0, 0,0, 0, 0,0,32'h0,          3,1,2,32'h0,          5,0,0,32'h0));
        vq.push_back(mk(1,0, 0, 0,0, 1, 3,2,32'hDEADBEEF,   3,0,0,32'hDEADBEEF,   3,0,0,32'hDEADBEEF));
        vq.push_back(mk(1,0, 0, 0,0, 0, 0,0,32'h0,          3,0,0,32'hDEADBEEF,   0,0,0,32'h0));
        vq.push_back(mk(1,0, 1, 4,1, 0, 0,0,32'h0,          4,0,0,32'h0,          3,0,0,32'hDEADBEEF));
        vq.push_back(mk(1,0, 1, 4,5, 0, 0,0,32'h0,          4,1,1,32'h0,          4,1,1,32'h0));
        vq.push_back(mk(1,0, 0, 0,0, 1, 4,1,32'h7,          4,1,5,32'h0,          4,1,5,32'h0));
        vq.push_back(mk(1,0, 0, 0,0, 0, 0,0,32'h0,          4,1,5,32'h0,          3,0,0,32'hDEADBEEF));
        vq.push_back(mk(1,0, 1, 6,1, 0, 0,0,32'h0,          6,0,0,32'h0,          4,1,5,32'h0));
        vq.push_back(mk(1,0, 1, 6,3, 1, 6,1,32'h9,          6,0,0,32'h9,          6,0,0,32'h9));
        vq.push_back(mk(1,0, 0, 0,0, 0, 0,0,32'h0,          6,1,3,32'h0,          0,0,0,32'h0));
        vq.push_back(mk(1,0, 0, 0,0, 1, 6,3,32'd11,         6,0,0,32'd11,         6,0,0,32'd11));
        vq.push_back(mk(1,0, 0, 0,0, 0, 0,0,32'h0,          6,0,0,32'd11,         4,1,5,32'h0));
        vq.push_back(mk(1,0, 0, 0,0, 1, 1,0,32'h11,         1,0,0,32'h0,          2,0,0,32'h0));
        vq.push_back(mk(1,0, 1, 1,1, 1, 2,0,32'h22,         1,0,0,32'h11,         2,0,0,32'h0));
        vq.push_back(mk(1,0, 1, 2,2, 0, 0,0,32'h0,          1,1,1,32'h0,          2,0,0,32'h22));
        vq.push_back(mk(1,1, 1, 5,6, 1, 7,0,32'h55,         1,1,1,32'h0,          2,1,2,32'h0));
        vq.push_back(mk(1,0, 0, 0,0, 0, 0,0,32'h0,          1,0,0,32'h11,         2,0,0,32'h22));
        vq.push_back(mk(1,0, 0, 0,0, 0, 0,0,32'h0,          7,0,0,32'h55,         4,0,0,32'h7));
        vq.push_back(mk(1,0, 0, 0,0, 0, 0,0,32'h0,          5,0,0,32'h0,          6,0,0,32'd11));
        vq.push_back(mk(1,0, 1, 0,7, 1, 0,0,32'hFF,         0,0,0,32'h0,          0,0,0,32'h0));
        vq.push_back(mk(1,0, 0, 0,0, 0, 0,0,32'h0,          0,0,0,32'h0,          5,0,0,32'h0));
        vq.push_back(mk(0,0, 1, 9,4, 1, 8,0,32'h1,          8,0,0,32'h0,          9,0,0,32'h0));
        vq.push_back(mk(1,0, 0, 0,0, 0, 0,0,32'h0,          8,0,0,32'h0,          9,0,0,32'h0));
        vq.push_back(mk(1,0, 1,10,9, 1, 5,0,32'hAB,         5,0,0,32'h0,         10,0,0,32'h0));
        vq.push_back(mk(1,0, 0, 0,0, 0, 0,0,32'h0,          5,0,0,32'hAB,        10,1,9,32'h0));
        vq.push_back(mk(0,0, 0, 0,0, 1,10,9,32'h77,        10,0,0,32'h77,        10,0,0,32'h77));
        vq.push_back(mk(1,0, 0, 0,0, 0, 0,0,32'h0,          5,0,0,32'hAB,        10,1,9,32'h0));

        idle = mk(1,0, 0,0,0, 0,0,0,32'h0, 0,0,0,32'h0, 0,0,0,32'h0);
        drive(idle);
        rst_in = 1'b0;
        #2;
        chk_ports("por", idle);
        @(posedge clk);
        #2 rst_in = 1'b1;
        @(posedge clk);
        #1;

        foreach (vq[i]) begin
            drive(vq[i]);
            @(negedge clk);
            chk_ports($sformatf("v%0d", i), vq[i]);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset mid-cycle while a commit and issue are presented.
        v = mk(1,0, 1,12,7, 1,5,0,32'h99, 5,0,0,32'h0, 12,0,0,32'h0);
        drive(v);
        bus.rs2_idx = 5'd10;
        #2 rst_in = 1'b0;
        #1;
        chk("rst_busy1", {31'd0, bus.rf_busy1}, 32'd0);
        chk("rst_val1",  bus.rf_val1, 32'd0);
        chk("rst_busy2", {31'd0, bus.rf_busy2}, 32'd0);
        chk("rst_label2", {28'd0, bus.rf_label2}, 32'd0);
        bus.rs2_idx = 5'd12;
        @(posedge clk);
        #1;
        chk("rst_hold_val5",  bus.rf_val1, 32'd0);
        chk("rst_hold_busy12", {31'd0, bus.rf_busy2}, 32'd0);

        bus.rdy_in = 1'b0;
        #1 rst_in = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy0_val5",  bus.rf_val1, 32'd0);
        chk("rdy0_busy12", {31'd0, bus.rf_busy2}, 32'd0);

        bus.rdy_in = 1'b1;
        @(posedge clk);
        #1;
        drive(idle);
        bus.rs1_idx = 5'd5;
        bus.rs2_idx = 5'd12;
        #1;
        chk("post_val5",    bus.rf_val1, 32'h99);
        chk("post_busy12",  {31'd0, bus.rf_busy2}, 32'd1);
        chk("post_label12", {28'd0, bus.rf_label2}, 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
